// File: rtl/layer_pkg.sv
// Shared types and default constants for the layer output-channel sequencer.
package layer_pkg;

    localparam int DEF_MAX_OC  = 8;
    localparam int DEF_CH_SIZE = 196;
    localparam int DEF_TIMEOUT = 4096;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_CONV = 3'd2,
        ST_POOL = 3'd3,
        ST_NEXT = 3'd4,
        ST_FIN  = 3'd5,
        ST_ERR  = 3'd6
    } layer_state_t;

    // Limit a requested channel count (minus one) to the supported range.
    function automatic int unsigned clamp_oc(input int unsigned cfg, input int unsigned max_oc);
        if (cfg >= max_oc) begin
            return max_oc - 32'd1;
        end else begin
            return cfg;
        end
    endfunction

endpackage

// File: rtl/layer_seq_if.sv
// Engine-side bundle of the sequencer: per-phase req/done pairs plus the
// channel index and output store base handed to the engines.
interface layer_seq_if #(
    parameter int OC_W         = 3,
    parameter int STORE_ADDR_W = 10
) ();
    logic                    kload_req;
    logic                    kload_done;
    logic                    conv_req;
    logic                    conv_done;
    logic                    pool_req;
    logic                    pool_done;
    logic [OC_W-1:0]         out_c;
    logic [STORE_ADDR_W-1:0] store_base;

    modport master (
        output kload_req, conv_req, pool_req, out_c, store_base,
        input  kload_done, conv_done, pool_done
    );

    modport slave (
        input  kload_req, conv_req, pool_req, out_c, store_base,
        output kload_done, conv_done, pool_done
    );
endinterface

// File: rtl/phase_watchdog.sv
// Per-phase cycle counter. `expired` rises during the TIMEOUT-th cycle of a
// phase, so the sequencer leaves the phase as the count reaches TIMEOUT.
module phase_watchdog #(
    parameter int TIMEOUT = 4096,
    parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [TO_W-1:0] cnt_r;

    assign expired = enable && (cnt_r == TO_W'(TIMEOUT - 1));

    // Count cycles spent in a handshake phase; restart on every phase change.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {TO_W{1'b0}};
        end else if (clear) begin
            cnt_r <= {TO_W{1'b0}};
        end else if (enable && !expired) begin
            cnt_r <= cnt_r + TO_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end
endmodule

// File: rtl/layer_seq.sv
// Output-channel sequencer for one CNN layer: per channel runs kernel/bias
// load, convolution and (optionally) pooling via req/done handshakes, with a
// per-phase watchdog. Optional pooling is enabled by LAYER_SEQ_POOL_EN.
module layer_seq
    import layer_pkg::*;
#(
    parameter int MAX_OC       = DEF_MAX_OC,
    parameter int OC_W         = $clog2(MAX_OC),
    parameter int STORE_ADDR_W = 10,
    parameter int CH_SIZE      = DEF_CH_SIZE,
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int TO_W         = $clog2(TIMEOUT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OC_W-1:0] cfg_oc,
    output logic            busy,
    output logic            done,
    output logic            err,
    layer_seq_if.master     eng
);
    layer_state_t            state_r;
    layer_state_t            state_s;
    logic [OC_W-1:0]         cfg_r;
    logic [OC_W-1:0]         out_c_r;
    logic [STORE_ADDR_W-1:0] base_r;
    logic                    accept_s;
    logic                    phase_s;
    logic                    expired_s;

    assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_ERR));
    assign phase_s  = (state_r == ST_LOAD) || (state_r == ST_CONV) || (state_r == ST_POOL);

    phase_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_s != state_r),
        .enable  (phase_s),
        .expired (expired_s)
    );

    // Next-state selection; a done arriving in the expiry cycle still wins.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_ERR: begin
                if (start) state_s = ST_LOAD;
                else       state_s = state_r;
            end
            ST_LOAD: begin
                if (eng.kload_done)  state_s = ST_CONV;
                else if (expired_s)  state_s = ST_ERR;
                else                 state_s = ST_LOAD;
            end
            ST_CONV: begin
`ifdef LAYER_SEQ_POOL_EN
                if (eng.conv_done)   state_s = ST_POOL;
`else
                if (eng.conv_done)   state_s = ST_NEXT;
`endif
                else if (expired_s)  state_s = ST_ERR;
                else                 state_s = ST_CONV;
            end
            ST_POOL: begin
`ifdef LAYER_SEQ_POOL_EN
                if (eng.pool_done)   state_s = ST_NEXT;
                else if (expired_s)  state_s = ST_ERR;
                else                 state_s = ST_POOL;
`else
                state_s = ST_IDLE;
`endif
            end
            ST_NEXT: begin
                if (out_c_r == cfg_r) state_s = ST_FIN;
                else                  state_s = ST_LOAD;
            end
            ST_FIN:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, latched channel count, channel index and incremental store base.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cfg_r   <= {OC_W{1'b0}};
            out_c_r <= {OC_W{1'b0}};
            base_r  <= {STORE_ADDR_W{1'b0}};
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                cfg_r   <= OC_W'(clamp_oc(32'(cfg_oc), 32'(MAX_OC)));
                out_c_r <= {OC_W{1'b0}};
                base_r  <= {STORE_ADDR_W{1'b0}};
            end else if ((state_r == ST_NEXT) && (out_c_r != cfg_r)) begin
                cfg_r   <= cfg_r;
                out_c_r <= out_c_r + OC_W'(1);
                base_r  <= base_r + STORE_ADDR_W'(CH_SIZE);
            end else begin
                cfg_r   <= cfg_r;
                out_c_r <= out_c_r;
                base_r  <= base_r;
            end
        end
    end

    assign busy           = (state_r != ST_IDLE) && (state_r != ST_ERR);
    assign done           = (state_r == ST_FIN);
    assign err            = (state_r == ST_ERR);
    assign eng.kload_req  = (state_r == ST_LOAD);
    assign eng.conv_req   = (state_r == ST_CONV);
`ifdef LAYER_SEQ_POOL_EN
    assign eng.pool_req   = (state_r == ST_POOL);
`else
    logic unused_pool_done;
    assign eng.pool_req   = 1'b0;
    assign unused_pool_done = eng.pool_done;
`endif
    assign eng.out_c      = out_c_r;
    assign eng.store_base = base_r;
endmodule

// File: tb/tb_layer_seq.sv
// Self-checking bench for layer_seq: table vectors, error/reset sequences and
// random runs compared cycle by cycle against a phase-duration trace model.
module tb_layer_seq;
    import layer_pkg::*;

    localparam int MAX_OC = 8;
    localparam int OC_W   = 3;
    localparam int SAW    = 10;
    localparam int CH     = 196;
    localparam int TO     = 16;
`ifdef LAYER_SEQ_POOL_EN
    localparam bit POOL = 1'b1;
`else
    localparam bit POOL = 1'b0;
`endif

    typedef struct packed {
        logic busy, done, err, kreq, creq, preq;
        logic [OC_W-1:0] oc;
        logic [SAW-1:0]  base;
    } obs_t;

    typedef struct {
        int cfg, lk, lc, lp;
        bit noise, tie;
        int exp_p, exp_n;
    } vec_t;

    logic clk = 1'b0;
    logic rst, start;
    logic [OC_W-1:0] cfg_oc;
    logic busy, done, err;

    int total = 0;
    int bad   = 0;

    int lat[3];
    int ecnt[3];
    bit tie_all  = 1'b0;
    bit noise_en = 1'b0;
    obs_t exp_q[$];
    vec_t vecs[4];

    layer_seq_if #(.OC_W(OC_W), .STORE_ADDR_W(SAW)) eng ();

    layer_seq #(
        .MAX_OC(MAX_OC), .STORE_ADDR_W(SAW), .CH_SIZE(CH), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_oc(cfg_oc),
        .busy(busy), .done(done), .err(err), .eng(eng)
    );

    always #5 clk = ~clk;

    // Engine responders: answer `lat` cycles after req rises (-1 never),
    // optionally tied high or toggling randomly while their req is low.
    initial begin
        bit r[3];
        bit d[3];
        eng.kload_done = 1'b0; eng.conv_done = 1'b0; eng.pool_done = 1'b0;
        forever begin
            @(negedge clk);
            r[0] = eng.kload_req; r[1] = eng.conv_req; r[2] = eng.pool_req;
            for (int i = 0; i < 3; i++) begin
                if (r[i]) ecnt[i] = ecnt[i] + 1; else ecnt[i] = 0;
                if (tie_all)   d[i] = 1'b1;
                else if (r[i]) d[i] = (lat[i] >= 0) && (ecnt[i] > lat[i]);
                else           d[i] = noise_en && ($urandom_range(0, 3) == 0);
            end
            eng.kload_done = d[0]; eng.conv_done = d[1]; eng.pool_done = d[2];
        end
    end

    function automatic obs_t observe();
        return '{busy, done, err, eng.kload_req, eng.conv_req, eng.pool_req,
                 eng.out_c, eng.store_base};
    endfunction

    function automatic obs_t mk(bit b, bit d, bit e, bit k, bit c, bit p, int oc, int base);
        return '{b, d, e, k, c, p, OC_W'(oc), SAW'(base)};
    endfunction

    task automatic check_obs(input obs_t want, input string name, input int cyc);
        obs_t got = observe();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    task automatic check_int(input int got, input int want, input string name);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Expected trace from start+1: each phase lasts latency+1 cycles, NEXT one
    // cycle per channel, then FIN and one idle cycle with held index/base.
    task automatic build_model(input int cfg, input int lk, input int lc, input int lp);
        int base;
        exp_q.delete();
        base = 0;
        for (int c = 0; c <= cfg; c++) begin
            base = (c * CH) % (1 << SAW);
            repeat (lk + 1) exp_q.push_back(mk(1, 0, 0, 1, 0, 0, c, base));
            repeat (lc + 1) exp_q.push_back(mk(1, 0, 0, 0, 1, 0, c, base));
            if (POOL) repeat (lp + 1) exp_q.push_back(mk(1, 0, 0, 0, 0, 1, c, base));
            exp_q.push_back(mk(1, 0, 0, 0, 0, 0, c, base));
        end
        exp_q.push_back(mk(1, 1, 0, 0, 0, 0, cfg, base));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, cfg, base));
    endtask

    task automatic run_vec(input int cfg, input int lk, input int lc, input int lp,
                           input bit noise, input bit tie, input int exp_done, input string name);
        int done_at = -1;
        int n_done  = 0;
        lat[0] = lk; lat[1] = lc; lat[2] = lp;
        noise_en = noise; tie_all = tie;
        build_model(cfg, lk, lc, lp);
        @(negedge clk);
        start = 1'b1; cfg_oc = OC_W'(cfg);
        for (int k = 1; k <= exp_q.size(); k++) begin
            @(negedge clk);
            if (noise && k < exp_q.size()) begin
                start  = ($urandom_range(0, 3) == 0);
                cfg_oc = OC_W'($urandom);
            end else begin
                start = 1'b0;
            end
            check_obs(exp_q[k-1], name, k);
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = k;
            end
        end
        start = 1'b0; tie_all = 1'b0; noise_en = 1'b0;
        check_int(done_at, exp_done, {name, "_done_cyc"});
        check_int(n_done, 1, {name, "_done_cnt"});
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int first_err, n_creq, n_done, lk, lc, lp, cfg;
        bit hit;
        vecs[0] = '{0, 0, 0, 0, 1'b0, 1'b1, 5, 4};
        vecs[1] = '{2, 3, 3, 3, 1'b0, 1'b0, 40, 28};
        vecs[2] = '{7, 0, 1, 2, 1'b1, 1'b0, 57, 33};
        vecs[3] = '{1, 5, 0, 1, 1'b1, 1'b0, 21, 17};
        lat[0] = 0; lat[1] = 0; lat[2] = 0;
        rst = 1'b1; start = 1'b0; cfg_oc = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check_obs(mk(0, 0, 0, 0, 0, 0, 0, 0), "reset_hold", 0);
        rst = 1'b0;
        @(negedge clk);
        check_obs(mk(0, 0, 0, 0, 0, 0, 0, 0), "reset_release", 0);

        // Table vectors.
        for (int v = 0; v < 4; v++) begin
            run_vec(vecs[v].cfg, vecs[v].lk, vecs[v].lc, vecs[v].lp, vecs[v].noise,
                    vecs[v].tie, POOL ? vecs[v].exp_p : vecs[v].exp_n, $sformatf("vec%0d", v));
        end

        // Hung convolution engine: watchdog abort, then restart clears err.
        lat[0] = 0; lat[1] = -1; lat[2] = 0;
        @(negedge clk);
        start = 1'b1; cfg_oc = 3'd2;
        first_err = -1; n_creq = 0; n_done = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (eng.conv_req) n_creq++;
            if (done) n_done++;
            if (err && first_err < 0) first_err = k;
            if (k == 18) check_obs(mk(0, 0, 1, 0, 0, 0, 0, 0), "wdog_err_state", k);
        end
        check_int(first_err, 18, "wdog_err_cyc");
        check_int(n_creq, TO, "wdog_conv_cycles");
        check_int(n_done, 0, "wdog_no_done");
        check_obs(mk(0, 0, 1, 0, 0, 0, 0, 0), "wdog_err_sticky", 40);
        run_vec(0, 0, 0, 0, 1'b0, 1'b0, POOL ? 5 : 4, "restart");

        // Reset in CONV of channel 1.
        lat[0] = 2; lat[1] = 2; lat[2] = 2;
        @(negedge clk);
        start = 1'b1; cfg_oc = 3'd3;
        hit = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (eng.conv_req && eng.out_c == 3'd1) hit = 1'b1;
        end
        check_int(int'(hit), 1, "rst_reach_conv1");
        rst = 1'b1;
        @(negedge clk);
        check_obs(mk(0, 0, 0, 0, 0, 0, 0, 0), "rst_midrun", 1);
        rst = 1'b0;
        @(negedge clk);
        check_obs(mk(0, 0, 0, 0, 0, 0, 0, 0), "rst_after", 2);

        // Random runs with spurious starts, cfg changes and stray done pulses.
        for (int r = 0; r < 20; r++) begin
            cfg = $urandom_range(0, MAX_OC - 1);
            lk  = $urandom_range(0, 5);
            lc  = $urandom_range(0, 5);
            lp  = $urandom_range(0, 5);
            run_vec(cfg, lk, lc, lp, 1'b1, 1'b0,
                    1 + (cfg + 1) * ((lk + 1) + (lc + 1) + (POOL ? lp + 1 : 0) + 1),
                    $sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/layer_seq.md
# layer_seq

Parametrised output-channel sequencer for one CNN layer. On `start` it steps through a run-time-selected number of output channels. For each channel it performs these phases in order, each through a req/done handshake with the sub-engines:

- kernel+bias load
- convolution
- optional pooling

It supplies the channel index and output store base address to those engines. A per-phase watchdog aborts a hung engine. It sits between the top-level network controller and the kernel loader, bias loader, conv array and pooling units of a layer.

## Interface
Parameters:
- `MAX_OC`, 8: maximum output channels supported.
- `OC_W`, `$clog2(MAX_OC)`: channel index width.
- `STORE_ADDR_W`, 10: store address width.
- `CH_SIZE`, 196: output words per channel, used as the base-address stride.
- `TIMEOUT`, 4096: maximum cycles allowed in any handshake phase.
- `TO_W`, `$clog2(TIMEOUT+1)`: watchdog width.

Ports:
- `clk`  in  1  sole clock; one clock, all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle run request; honoured only in IDLE or ERR.
- `cfg_oc`  in  OC_W  number of channels minus one; latched on accepted `start`.
- `busy`  out  1  high in every state except IDLE and ERR.
- `done`  out  1  one-cycle pulse when the last channel completes.
- `err`  out  1  sticky watchdog abort flag.
- `out_c`  out  OC_W  current channel index.
- `store_base`  out  STORE_ADDR_W  equals `out_c*CH_SIZE`, maintained incrementally.
- `kload_req` out 1 / `kload_done` in 1: kernel+bias load handshake.
- `conv_req` out 1 / `conv_done` in 1: convolution handshake.
- `pool_req` out 1 / `pool_done` in 1: pooling handshake.

## Operation
- States: IDLE, LOAD, CONV, POOL, NEXT, FIN, ERR. The state register is the only source of the req outputs.
- Request mapping: `kload_req` = (state==LOAD), `conv_req` = (state==CONV), `pool_req` = (state==POOL).
- IDLE/ERR + `start`: latch `cfg_oc`, set `out_c`=0, `store_base`=0, clear `err`, go to LOAD.
- LOAD + `kload_done` → CONV.
- CONV + `conv_done` → POOL. Without pooling compiled in, CONV + `conv_done` → NEXT.
- POOL + `pool_done` → NEXT.
- NEXT, when `out_c` == latched `cfg_oc`: go to FIN.
- NEXT otherwise: `out_c`+1, `store_base`+`CH_SIZE`, go to LOAD.
- FIN: `done`=1 for exactly one cycle, then go to IDLE. `out_c` and `store_base` hold their last values until the next `start`.
- Done inputs are sampled only in their own phase. Done pulses arriving in any other state are ignored.
- Watchdog: cleared on every state change, increments each cycle spent in LOAD/CONV/POOL.
  - When it reaches `TIMEOUT` without the matching done: go to ERR, set `err`=1, drop all reqs, no `done` pulse.
- `start` while busy is ignored. A `cfg_oc` change while busy has no effect.
- `cfg_oc` ≥ `MAX_OC` is clamped to `MAX_OC-1` at latch time.
- `store_base` width rule: the value is truncated to STORE_ADDR_W bits. Callers must size `MAX_OC*CH_SIZE` to fit.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `err`=0, `out_c`=0, `store_base`=0, all reqs 0, watchdog 0.
- `rst` mid-run returns to IDLE on the next edge, reqs deassert that same edge, no `done` pulse.
- `start` accepted at cycle t: `kload_req` and `busy` are high from t+1.
- A req stays high through the cycle its done is sampled, and is low the following cycle. Minimum req width is 1 cycle.
- The next phase's req rises in the same cycle the previous one falls. There is no gap and no overlap.
- Per-channel overhead: 1 cycle (NEXT) plus the phase durations.
- With zero-latency engines (done tied high) and pooling compiled in, a 1-channel run gives `done` at t+5.
  - Each additional channel adds 4 cycles.
- `start` in the FIN cycle is ignored.

## Configuration
- `LAYER_SEQ_POOL_EN` defined: the POOL state exists, `pool_req` is driven per channel, and `pool_done` is used.
- `LAYER_SEQ_POOL_EN` undefined: POOL logic is removed, `pool_req` is tied 0, `pool_done` is unused, and CONV goes directly to NEXT.
  - Zero-latency 1-channel run then gives `done` at t+4.

## Structure
- Shared package `layer_pkg`: the state enum `layer_state_t` and the default constants (`MAX_OC`, `CH_SIZE`, `TIMEOUT`).
- One natural sub-module, `phase_watchdog`: the counter with clear, enable and `TIMEOUT` compare, producing `expired`.

## Test plan
- `cfg_oc`=2, engines answer `done` 3 cycles after req → `out_c` sequence 0,1,2, `store_base` 0,196,392, one `done` pulse, `busy` low the cycle after.
- All done inputs tied high, `cfg_oc`=0 → `done` at t+5 with pooling compiled in, t+4 without.
- `conv_done` never asserted, `TIMEOUT`=16 → ERR after 16 cycles in CONV, `err`=1, `conv_req`=0, no `done`. A new `start` clears `err` and restarts at `out_c`=0.
- `start` and a `cfg_oc` change during a run → no restart, original count completes.
- `rst` asserted while in CONV with `out_c`=1 → next cycle all outputs at reset values.
- Spurious `pool_done` in LOAD and `kload_done` in CONV → ignored, sequence unchanged.
